// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory-bus request slot among NUM_REQ requesters,
// routing read responses back by BusID and limiting each requester to one outstanding read.
module memory_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      bus_req_valid,
    output logic [1:0]                bus_req_kind,
    output logic [ID_W-1:0]           bus_req_source,
    output logic [ADDR_W-1:0]         bus_req_addr,
    output logic [DATA_W-1:0]         bus_req_data,
    input  logic                      bus_req_accept,
    input  logic                      bus_rsp_valid,
    input  logic [ID_W-1:0]           bus_rsp_source,
    input  logic [DATA_W-1:0]         bus_rsp_data,
    output logic                      bus_rsp_accept,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]        read_pending
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef enum logic [1:0] {
        KIND_READ  = 2'd0,
        KIND_WRITE = 2'd1
    } bus_kind_e;

    state_e             state_q;
    state_e             state_d;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   next_ptr;
    logic               grant_any;
    logic               load_slot;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] pending_set;
    logic [NUM_REQ-1:0] pending_clr;
    logic               rsp_good;

    function automatic int wrap_idx(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // A requester with a read in flight may still issue writes, but not another read.
    assign eligible = req_valid & ~(~req_write & read_pending);

    always_comb begin
        // NOTE: every variable gets a default before the search so no path leaves it unassigned (no latch).
        grant_any = 1'b0;
        winner    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && eligible[wrap_idx(int'(rr_ptr) + k)]) begin
                grant_any = 1'b1;
                winner    = PTR_W'(wrap_idx(int'(rr_ptr) + k));
            end
        end
        grant_oh = grant_any ? (NUM_REQ'(1) << winner) : '0;
        next_ptr = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end

    // Request-slot FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
            state_q <= state_d;
        end
    end

    // Request-slot FSM: next state and grant. Combinational outputs are forced low while
    // reset is asserted so the whole interface reads as idle during reset.
    always_comb begin
        state_d   = state_q;
        load_slot = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_any && reset_n) begin
                    load_slot = 1'b1;
                    req_ready = grant_oh;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (bus_req_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot contents stay frozen while BUSY; only the valid flag drops on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_req_valid  <= 1'b0;
            bus_req_kind   <= KIND_READ;
            bus_req_source <= '0;
            bus_req_addr   <= '0;
            bus_req_data   <= '0;
            rr_ptr         <= '0;
        end else if (load_slot) begin
            bus_req_valid  <= 1'b1;
            bus_req_kind   <= req_write[winner] ? KIND_WRITE : KIND_READ;
            bus_req_source <= ID_W'(winner);
            bus_req_addr   <= req_addr[winner*ADDR_W +: ADDR_W];
            bus_req_data   <= req_write[winner] ? req_data[winner*DATA_W +: DATA_W] : '0;
            rr_ptr         <= next_ptr;
        end else if (state_q == BUSY && bus_req_accept) begin
            bus_req_valid  <= 1'b0;
        end
    end

    // Responses are always taken; only those matching an outstanding read are forwarded.
    assign bus_rsp_accept = bus_rsp_valid & reset_n;

    always_comb begin
        pending_clr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pending_clr[i] = bus_rsp_valid && (bus_rsp_source == ID_W'(i)) && read_pending[i];
        end
        rsp_good    = |pending_clr;
        pending_set = grant_oh & ~req_write & {NUM_REQ{load_slot}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pending <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
        end else begin
            read_pending <= (read_pending | pending_set) & ~pending_clr;
            rsp_valid    <= pending_clr;
            if (rsp_good) begin
                rsp_data <= bus_rsp_data;
            end
        end
    end

    a_accept_when_busy : assert property (
        @(posedge clk) disable iff (!reset_n) bus_req_accept |-> state_q == BUSY
    ) else $warning("bus_req_accept seen with an empty request slot");

    a_rsp_has_owner : assert property (
        @(posedge clk) disable iff (!reset_n) bus_rsp_valid |-> rsp_good
    ) else $warning("response for source %0d has no outstanding read; dropped", bus_rsp_source);

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: a cycle table for arbitration/response flow,
// plus hand-written slot-stall and mid-transaction reset sequences.
module tb_memory_bus_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      bus_req_valid;
    logic [1:0]                bus_req_kind;
    logic [ID_W-1:0]           bus_req_source;
    logic [ADDR_W-1:0]         bus_req_addr;
    logic [DATA_W-1:0]         bus_req_data;
    logic                      bus_req_accept;
    logic                      bus_rsp_valid;
    logic [ID_W-1:0]           bus_rsp_source;
    logic [DATA_W-1:0]         bus_rsp_data;
    logic                      bus_rsp_accept;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [NUM_REQ-1:0]        read_pending;

    memory_bus_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .bus_req_valid(bus_req_valid), .bus_req_kind(bus_req_kind), .bus_req_source(bus_req_source),
        .bus_req_addr(bus_req_addr), .bus_req_data(bus_req_data), .bus_req_accept(bus_req_accept),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_source(bus_rsp_source), .bus_rsp_data(bus_rsp_data),
        .bus_rsp_accept(bus_rsp_accept),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .read_pending(read_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  rw;
        logic        acc;
        logic        rsp_v;
        logic [2:0]  rsp_src;
        logic [63:0] rsp_dat;
        logic [3:0]  e_ready;
        logic        e_bvalid;
        logic [2:0]  e_src;
        logic [1:0]  e_kind;
        logic [3:0]  e_pend;
        logic [3:0]  e_rspv;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] exp_addr(input int src);
        return 32'(src) * 32'h40;
    endfunction

    function automatic logic [63:0] exp_wdata(input int src);
        return 64'hD000_0000_0000_0000 | 64'(src);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(
        input logic [3:0] rv, input logic [3:0] rw, input logic acc,
        input logic rsp_v, input logic [2:0] rsp_src, input logic [63:0] rsp_dat,
        input logic [3:0] e_ready, input logic e_bvalid, input logic [2:0] e_src,
        input logic [1:0] e_kind, input logic [3:0] e_pend, input logic [3:0] e_rspv,
        input logic [63:0] e_rdata);
        vec_t v;
        v.rv = rv; v.rw = rw; v.acc = acc; v.rsp_v = rsp_v; v.rsp_src = rsp_src; v.rsp_dat = rsp_dat;
        v.e_ready = e_ready; v.e_bvalid = e_bvalid; v.e_src = e_src; v.e_kind = e_kind;
        v.e_pend = e_pend; v.e_rspv = e_rspv; v.e_rdata = e_rdata;
        vecs.push_back(v);
    endfunction

    task automatic check_slot(input string tag, input int src, input int kind);
        check({tag, " bus_req_valid"}, 64'(bus_req_valid), 64'd1);
        check({tag, " source"}, 64'(bus_req_source), 64'(src));
        check({tag, " kind"}, 64'(bus_req_kind), 64'(kind));
        check({tag, " addr"}, 64'(bus_req_addr), 64'(exp_addr(src)));
        check({tag, " data"}, bus_req_data, (kind == 1) ? exp_wdata(src) : 64'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        req_valid      = '0;
        req_write      = '0;
        bus_req_accept = 1'b0;
        bus_rsp_valid  = 1'b0;
        bus_rsp_source = '0;
        bus_rsp_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = exp_addr(i);
            req_data[i*DATA_W +: DATA_W] = exp_wdata(i);
        end

        // Round-robin: all four writing, accept whenever the slot is full.
        for (int g = 0; g < 8; g++) begin
            add(4'b1111, 4'b1111, 1'b0, 1'b0, 3'd0, 64'd0,
                4'(1 << (g % 4)), 1'b0, 3'd0, 2'd0, 4'b0000, 4'b0000, 64'd0);
            add(4'b1111, 4'b1111, 1'b1, 1'b0, 3'd0, 64'd0,
                4'b0000, 1'b1, 3'(g % 4), 2'd1, 4'b0000, 4'b0000, 64'd0);
        end
        // Single read from requester 1 and its response.
        add(4'b0010, 4'b0000, 1'b0, 1'b0, 3'd0, 64'd0,      4'b0010, 1'b0, 3'd0, 2'd0, 4'b0000, 4'b0000, 64'd0);
        add(4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 64'd0,      4'b0000, 1'b1, 3'd1, 2'd0, 4'b0010, 4'b0000, 64'd0);
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 3'd1, 64'hDEAD,   4'b0000, 1'b0, 3'd0, 2'd0, 4'b0010, 4'b0000, 64'd0);
        add(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 64'd0,      4'b0000, 1'b0, 3'd0, 2'd0, 4'b0000, 4'b0010, 64'hDEAD);
        add(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 64'd0,      4'b0000, 1'b0, 3'd0, 2'd0, 4'b0000, 4'b0000, 64'hDEAD);
        // Outstanding-read block for requester 2 while requester 3 writes (rr_ptr = 2).
        add(4'b0100, 4'b0000, 1'b0, 1'b0, 3'd0, 64'd0,      4'b0100, 1'b0, 3'd0, 2'd0, 4'b0000, 4'b0000, 64'hDEAD);
        add(4'b1100, 4'b1000, 1'b1, 1'b0, 3'd0, 64'd0,      4'b0000, 1'b1, 3'd2, 2'd0, 4'b0100, 4'b0000, 64'hDEAD);
        add(4'b1100, 4'b1000, 1'b0, 1'b0, 3'd0, 64'd0,      4'b1000, 1'b0, 3'd0, 2'd0, 4'b0100, 4'b0000, 64'hDEAD);
        add(4'b0100, 4'b0000, 1'b1, 1'b0, 3'd0, 64'd0,      4'b0000, 1'b1, 3'd3, 2'd1, 4'b0100, 4'b0000, 64'hDEAD);
        add(4'b0100, 4'b0000, 1'b0, 1'b1, 3'd2, 64'hBEEF,   4'b0000, 1'b0, 3'd0, 2'd0, 4'b0100, 4'b0000, 64'hDEAD);
        add(4'b0100, 4'b0000, 1'b0, 1'b0, 3'd0, 64'd0,      4'b0100, 1'b0, 3'd0, 2'd0, 4'b0000, 4'b0100, 64'hBEEF);
        add(4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 64'd0,      4'b0000, 1'b1, 3'd2, 2'd0, 4'b0100, 4'b0000, 64'hBEEF);
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 3'd2, 64'h1234,   4'b0000, 1'b0, 3'd0, 2'd0, 4'b0100, 4'b0000, 64'hBEEF);
        add(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 64'd0,      4'b0000, 1'b0, 3'd0, 2'd0, 4'b0000, 4'b0100, 64'h1234);
        // Stray responses: no pending read, and a source beyond NUM_REQ.
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 3'd3, 64'hBAD0,   4'b0000, 1'b0, 3'd0, 2'd0, 4'b0000, 4'b0000, 64'h1234);
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 3'd5, 64'hBAD1,   4'b0000, 1'b0, 3'd0, 2'd0, 4'b0000, 4'b0000, 64'h1234);
        add(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 64'd0,      4'b0000, 1'b0, 3'd0, 2'd0, 4'b0000, 4'b0000, 64'h1234);

        // Reset values.
        #12;
        check("reset bus_req_valid", 64'(bus_req_valid), 64'd0);
        check("reset read_pending", 64'(read_pending), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_data", rsp_data, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            req_valid      = vecs[i].rv;
            req_write      = vecs[i].rw;
            bus_req_accept = vecs[i].acc;
            bus_rsp_valid  = vecs[i].rsp_v;
            bus_rsp_source = vecs[i].rsp_src;
            bus_rsp_data   = vecs[i].rsp_dat;
            #1;
            check($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(vecs[i].e_ready));
            check($sformatf("vec%0d read_pending", i), 64'(read_pending), 64'(vecs[i].e_pend));
            check($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].e_rspv));
            check($sformatf("vec%0d rsp_data", i), rsp_data, vecs[i].e_rdata);
            check($sformatf("vec%0d bus_rsp_accept", i), 64'(bus_rsp_accept), 64'(vecs[i].rsp_v));
            if (vecs[i].e_bvalid) begin
                check_slot($sformatf("vec%0d", i), int'(vecs[i].e_src), int'(vecs[i].e_kind));
            end else begin
                check($sformatf("vec%0d bus_req_valid", i), 64'(bus_req_valid), 64'd0);
            end
        end

        // Slot stall: rr_ptr = 3, requesters 0 and 1 write; 0 wins, slot held 5 cycles.
        @(negedge clk);
        req_valid = 4'b0011; req_write = 4'b0011; bus_req_accept = 1'b0; bus_rsp_valid = 1'b0;
        #1 check("stall grant", 64'(req_ready), 64'b0001);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check_slot($sformatf("stall c%0d", c), 0, 1);
            check($sformatf("stall c%0d req_ready", c), 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        bus_req_accept = 1'b1;
        @(negedge clk);
        bus_req_accept = 1'b0;
        #1 check("stall next grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0; bus_req_accept = 1'b1;
        #1 check_slot("stall regrant", 1, 1);
        @(negedge clk);
        bus_req_accept = 1'b0;

        // Reset mid-BUSY with requester 0's read in flight (rr_ptr = 2 beforehand).
        req_valid = 4'b0001; req_write = 4'b0000;
        #1 check("rst pre grant", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = 4'b0011; req_write = 4'b0011;
        #1;
        check_slot("rst pre slot", 0, 0);
        check("rst pre pending", 64'(read_pending), 64'b0001);
        #2 reset_n = 1'b0;
        #1;
        check("rst bus_req_valid", 64'(bus_req_valid), 64'd0);
        check("rst kind", 64'(bus_req_kind), 64'd0);
        check("rst source", 64'(bus_req_source), 64'd0);
        check("rst addr", 64'(bus_req_addr), 64'd0);
        check("rst data", bus_req_data, 64'd0);
        check("rst req_ready", 64'(req_ready), 64'd0);
        check("rst pending", 64'(read_pending), 64'd0);
        check("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst rsp_data", rsp_data, 64'd0);
        check("rst bus_rsp_accept", 64'(bus_rsp_accept), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("post-rst grant rr0", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = '0; bus_req_accept = 1'b1;
        #1 check_slot("post-rst slot", 0, 1);
        @(negedge clk);
        bus_req_accept = 1'b0;
        #1 check("post-rst idle", 64'(bus_req_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
